// File: rtl/grn_if.sv
// Sample stream bundle between the Gaussian generator and its consumer.
// The driver side owns control and seeding; the generator side owns the data.
interface grn_if;
  logic        en;
  logic [31:0] seed;
  logic        seed_load;
  logic        ready;
  logic [31:0] dout;
  logic        valid;

  modport master (
    output en, seed, seed_load, ready,
    input  dout, valid
  );

  modport slave (
    input  en, seed, seed_load, ready,
    output dout, valid
  );
endinterface

// File: rtl/grn_gen.sv
// CLT Gaussian generator: 6 xorshift32 lanes, 5-stage sum-and-pack pipe.
// Optional ramp override of the S3 value: GRN_TEST_PATTERN_EN.
module grn_gen #(
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
  parameter logic [31:0] LANE_MIX     = 32'h9E37_79B9
) (
  input  logic clk,
  input  logic reset,
`ifdef GRN_TEST_PATTERN_EN
  input  logic test_en,
`endif
  grn_if.slave bus
);

  localparam logic [19:0] OFFSET = 20'h6_0000;

  function automatic logic [31:0] lane_seed(
    input logic [31:0] s,
    input logic [2:0]  i
  );
    logic [31:0] x;
    x = s ^ (LANE_MIX * {29'b0, i});
    return (x == 32'h0) ? 32'h1 : x;
  endfunction

  function automatic logic [31:0] xs_step(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [31:0] lane [6];

  logic [15:0] u1 [12];
  logic        v1;
  logic [16:0] p2 [6];
  logic        v2;
  logic [19:0] s3;
  logic        v3;
  logic        sg4;
  logic [18:0] m4;
  logic [4:0]  e4;
  logic        z4;
  logic        v4;
  logic [31:0] dout_q;
  logic        v5;

`ifdef GRN_TEST_PATTERN_EN
  logic [19:0] ramp;
  logic [19:0] ramp_nxt;
  logic        t1;
  logic        t2;
  logic [19:0] r1;
  logic [19:0] r2;
`endif

  logic        advance;
  logic [19:0] total;
  logic [19:0] v_nxt;
  logic        neg;
  logic [18:0] mag;
  logic [4:0]  pos;
  logic [22:0] mant;
  logic [7:0]  expo;
  logic [31:0] packed_f;

  assign advance   = bus.ready | ~v5;
  assign bus.dout  = dout_q;
  assign bus.valid = v5;

`ifdef GRN_TEST_PATTERN_EN
  // ramp walks -6.0 .. +5.75 in quarter steps
  assign ramp_nxt = (ramp == 20'h5_C000) ? 20'hA_0000
                                         : ramp + 20'h0_4000;
`endif

  always_comb begin
    total = '0;
    for (int k = 0; k < 6; k++) begin
      total = total + {3'b0, p2[k]};
    end
    v_nxt = total - OFFSET;
`ifdef GRN_TEST_PATTERN_EN
    if (t2) v_nxt = r2;
`endif
  end

  always_comb begin
    neg = s3[19];
    mag = neg ? 19'(-s3) : s3[18:0];
    pos = '0;
    for (int k = 0; k < 19; k++) begin
      if (mag[k]) pos = 5'(k);
    end
  end

  always_comb begin
    mant = 23'({5'b0, m4} << (5'd23 - e4));
    expo = 8'd111 + {3'b0, e4};
    packed_f = z4 ? 32'h0 : {sg4, expo, mant};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) begin
        lane[k] <= lane_seed(SEED_DEFAULT, 3'(k));
      end
      {v1, v2, v3, v4, v5} <= '0;
      dout_q <= 32'h0;
`ifdef GRN_TEST_PATTERN_EN
      ramp <= '0;
`endif
    end else if (bus.seed_load) begin
      for (int k = 0; k < 6; k++) begin
        lane[k] <= lane_seed(bus.seed, 3'(k));
      end
      {v1, v2, v3, v4, v5} <= '0;
`ifdef GRN_TEST_PATTERN_EN
      ramp <= '0;
`endif
    end else if (advance) begin
      v1 <= bus.en;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      v5 <= v4;
      if (bus.en) begin
        for (int k = 0; k < 6; k++) begin
          u1[2*k]   <= lane[k][31:16];
          u1[2*k+1] <= lane[k][15:0];
          lane[k]   <= xs_step(lane[k]);
        end
`ifdef GRN_TEST_PATTERN_EN
        t1   <= test_en;
        r1   <= ramp;
        ramp <= ramp_nxt;
`endif
      end
      if (v1) begin
        for (int k = 0; k < 6; k++) begin
          p2[k] <= {1'b0, u1[2*k]} + {1'b0, u1[2*k+1]};
        end
`ifdef GRN_TEST_PATTERN_EN
        t2 <= t1;
        r2 <= r1;
`endif
      end
      if (v2) s3 <= v_nxt;
      if (v3) begin
        sg4 <= neg;
        m4  <= mag;
        e4  <= pos;
        z4  <= (s3 == 20'h0);
      end
      if (v4) dout_q <= packed_f;
    end
  end

endmodule

// File: tb/tb_grn_gen.sv
// Scoreboard bench for grn_gen: lane model plus double-based float reference.
// Hand-derived first samples for seed 1 and seed 0 anchor the model.
module tb_grn_gen;
  localparam logic [31:0] MIX = 32'h9E37_79B9;

  logic clk = 1'b0;
  logic reset;
  grn_if bus();

  grn_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ml [6];
  logic [5:1]  mv = '0;
  logic [31:0] q [$];
  logic        zero_flag = 1'b0;
  logic        hand_pending = 1'b0;
  logic [31:0] hand_exp = '0;
  logic        stat_on = 1'b0;
  int          n_stat = 0;
  real         s_sum = 0.0;
  real         s_sq = 0.0;
  real         s_min = 0.0;
  real         s_max = 0.0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_seed(input logic [31:0] s,
                                         input int i);
    logic [31:0] x;
    x = s ^ (MIX * 32'(i));
    return (x == 0) ? 32'h1 : x;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction

  function automatic logic [31:0] to_f(input int v);
    logic [63:0] b;
    int e;
    if (v == 0) return 32'h0;
    b = $realtobits(v / 65536.0);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], 8'(e), b[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real r;
    int e;
    if (f[30:0] == 0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] m_sample();
    int sum;
    sum = 0;
    for (int k = 0; k < 6; k++) begin
      sum += int'(ml[k][31:16]) + int'(ml[k][15:0]);
    end
    return to_f(sum - 393216);
  endfunction

  // reference model of lanes, stage occupancy and expected stream
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) ml[k] = m_seed(32'h1, k);
      mv = '0;
      q.delete();
      zero_flag = 1'b1;
      hand_pending = 1'b1;
      hand_exp = 32'hBF18_EC00;
    end else if (bus.seed_load) begin
      for (int k = 0; k < 6; k++) ml[k] = m_seed(bus.seed, k);
      mv = '0;
      q.delete();
      hand_pending = (bus.seed == 32'h0);
      hand_exp = 32'hBF18_EB00;
    end else if (bus.ready || !mv[5]) begin
      mv = {mv[4:1], bus.en};
      if (mv[5]) zero_flag = 1'b0;
      if (bus.en) begin
        q.push_back(m_sample());
        for (int k = 0; k < 6; k++) ml[k] = m_step(ml[k]);
      end
    end
  end

  always @(negedge clk) begin
    real r;
    chk("valid", {31'b0, bus.valid}, {31'b0, mv[5]});
    if (mv[5]) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty: got %h expected none", bus.dout);
      end else begin
        chk("dout", bus.dout, q[0]);
        if (hand_pending) begin
          chk("hand_first", bus.dout, hand_exp);
          hand_pending = 1'b0;
        end
        if (bus.ready) begin
          if (stat_on) begin
            r = f2r(bus.dout);
            s_sum += r;
            s_sq += r * r;
            if (r < s_min) s_min = r;
            if (r > s_max) s_max = r;
            n_stat++;
          end
          void'(q.pop_front());
        end
      end
    end else if (zero_flag) begin
      chk("dout_reset", bus.dout, 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stat_chk(input string nm, input real act,
                          input real lo, input real hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %f expected [%f,%f]", nm, act, lo, hi);
    end
  endtask

  initial begin
    real mean;
    real var_s;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.seed = 32'h0;
    bus.seed_load = 1'b0;
    bus.ready = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    bus.en = 1'b1;
    tick(12);
    bus.ready = 1'b0;
    tick(3);
    bus.ready = 1'b1;
    tick(5);
    bus.en = 1'b0; tick(1);
    bus.en = 1'b1; tick(1);
    bus.en = 1'b0; tick(1);
    bus.en = 1'b1; tick(1);
    bus.en = 1'b0; tick(1);
    bus.en = 1'b1; tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus.en = 1'b0;
    tick(3);
    bus.en = 1'b1;
    tick(8);
    bus.seed = 32'h0;
    bus.seed_load = 1'b1;
    tick(1);
    bus.seed_load = 1'b0;
    tick(10);
    reset = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed = 32'hDEAD_BEEF;
    tick(1);
    reset = 1'b0;
    bus.seed_load = 1'b0;
    tick(10);
    bus.en = 1'b0;
    bus.seed = 32'h1234_5678;
    bus.seed_load = 1'b1;
    tick(1);
    bus.seed_load = 1'b0;
    stat_on = 1'b1;
    bus.en = 1'b1;
    tick(8192);
    bus.en = 1'b0;
    tick(6);
    stat_on = 1'b0;
    chk("stat_count", n_stat, 8192);
    mean = s_sum / 8192.0;
    var_s = s_sq / 8192.0 - mean * mean;
    stat_chk("stat_mean", mean, -0.05, 0.05);
    stat_chk("stat_var", var_s, 0.9, 1.1);
    stat_chk("stat_min", s_min, -6.0, 0.0);
    stat_chk("stat_max", s_max, 0.0, 6.0);
    bus.en = 1'b1;
    repeat (200) begin
      bus.ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    bus.ready = 1'b1;
    bus.en = 1'b0;
    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
